// File: rtl/pieo_post_deq_priority_if.sv
// PIEO dequeue, transmit and re-enqueue handshake bundle
// master = scheduler side, slave = PIEO / downstream / tracker side
interface pieo_post_deq_priority_if #(
  parameter int NUM_FIFO = 3,
  parameter int ID_LOG   = 2,
  parameter int RANK_LOG = 1,
  parameter int TIME_LOG = 1
);
  localparam int ELEM_W = ID_LOG + RANK_LOG + TIME_LOG;

  logic                pieo_ready_for_deq;
  logic                pieo_deq_trigger;
  logic                pieo_deq_valid;
  logic                pieo_deq_empty;
  logic [ELEM_W-1:0]   pieo_deq_element;
  logic [NUM_FIFO-1:0] fifo_empty;
  logic                tx_enable;
  logic                tx_req;
  logic [ID_LOG-1:0]   tx_fifo_id;
  logic [RANK_LOG-1:0] tx_rank;
  logic                tx_ack;
  logic                tx_done;
  logic                reenq_valid;
  logic [ID_LOG-1:0]   reenq_fifo_id;
  logic                reenq_ready;

  modport master (
    input  pieo_ready_for_deq, pieo_deq_valid,
    input  pieo_deq_empty, pieo_deq_element,
    input  fifo_empty, tx_enable, tx_ack,
    input  tx_done, reenq_ready,
    output pieo_deq_trigger, tx_req, tx_fifo_id,
    output tx_rank, reenq_valid, reenq_fifo_id
  );

  modport slave (
    output pieo_ready_for_deq, pieo_deq_valid,
    output pieo_deq_empty, pieo_deq_element,
    output fifo_empty, tx_enable, tx_ack,
    output tx_done, reenq_ready,
    input  pieo_deq_trigger, tx_req, tx_fifo_id,
    input  tx_rank, reenq_valid, reenq_fifo_id
  );
endinterface

// File: rtl/pieo_post_deq_priority.sv
// Dequeue-side scheduler: pull PIEO head, transmit from its FIFO,
// and hand the FIFO ID back for re-insertion while it still has packets
module pieo_post_deq_priority #(
  parameter int NUM_FIFO    = 3,
  parameter int ID_LOG      = 2,
  parameter int RANK_LOG    = 1,
  parameter int TIME_LOG    = 1,
  parameter int TIMEOUT_LOG = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pieo_post_deq_priority_if.master bus,
  output logic             busy,
  output logic             err_pulse,
  output logic [CNT_W-1:0] deq_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_ELEM,
    S_TX, S_WAIT_DONE, S_REENQ
  } state_t;

  state_t state_q, state_d;

  logic [TIMEOUT_LOG-1:0] tmo_q, tmo_d, tmo_inc;
  logic                   tmo_hit;

  logic                trig_q, trig_d;
  logic                txr_q, txr_d;
  logic [ID_LOG-1:0]   txid_q, txid_d;
  logic [RANK_LOG-1:0] txrk_q, txrk_d;
  logic                rev_q, rev_d;
  logic [ID_LOG-1:0]   reid_q, reid_d;
  logic                errp_q, errp_d;
  logic [CNT_W-1:0]    deqc_q, deqc_d;
  logic [CNT_W-1:0]    errc_q, errc_d;

  logic [ID_LOG-1:0]   elem_id;
  logic [RANK_LOG-1:0] elem_rank;
  logic [TIME_LOG-1:0] unused_time;
  logic                id_bad;
  logic                fifo_keep;
  logic                start;

  // send_time only matters to the PIEO; it is unpacked and dropped here
  assign elem_id     = bus.pieo_deq_element[ID_LOG-1:0];
  assign elem_rank   = bus.pieo_deq_element[ID_LOG+:RANK_LOG];
  assign unused_time = bus.pieo_deq_element[ID_LOG+RANK_LOG+:TIME_LOG];
  assign id_bad      = int'(elem_id) >= NUM_FIFO;
  assign fifo_keep   = !bus.fifo_empty[txid_q];
  assign start       = bus.pieo_ready_for_deq && bus.tx_enable;
  assign tmo_inc     = tmo_q + 1'b1;
  assign tmo_hit     = tmo_inc == {TIMEOUT_LOG{1'b1}};

  // state, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      trig_q  <= 1'b0;
      txr_q   <= 1'b0;
      txid_q  <= '0;
      txrk_q  <= '0;
      rev_q   <= 1'b0;
      reid_q  <= '0;
      errp_q  <= 1'b0;
      deqc_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      trig_q  <= trig_d;
      txr_q   <= txr_d;
      txid_q  <= txid_d;
      txrk_q  <= txrk_d;
      rev_q   <= rev_d;
      reid_q  <= reid_d;
      errp_q  <= errp_d;
      deqc_q  <= deqc_d;
      errc_q  <= errc_d;
    end
  end

  // next-state and element-wait timeout
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT_ELEM;
        tmo_d   = '0;
      end
      S_WAIT_ELEM: begin
        if (bus.pieo_deq_valid) begin
          if (bus.pieo_deq_empty || id_bad)
            state_d = S_IDLE;
          else
            state_d = S_TX;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) state_d = S_IDLE;
        end
      end
      S_TX: begin
        if (bus.tx_ack) begin
          if (!bus.tx_done)
            state_d = S_WAIT_DONE;
          else if (fifo_keep)
            state_d = S_REENQ;
          else
            state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done)
          state_d = fifo_keep ? S_REENQ : S_IDLE;
      end
      S_REENQ: begin
        if (bus.reenq_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // next values of the registered outputs and statistics
  always_comb begin
    trig_d = 1'b0;
    txr_d  = txr_q;
    txid_d = txid_q;
    txrk_d = txrk_q;
    rev_d  = rev_q;
    reid_d = reid_q;
    errp_d = 1'b0;
    deqc_d = deqc_q;
    errc_d = errc_q;
    unique case (state_q)
      S_IDLE: begin
        trig_d = start;
      end
      S_REQ: begin
      end
      S_WAIT_ELEM: begin
        if (bus.pieo_deq_valid) begin
          if (!bus.pieo_deq_empty) begin
            if (id_bad) begin
              errp_d = 1'b1;
              errc_d = errc_q + CNT_W'(1);
            end else begin
              txid_d = elem_id;
              txrk_d = elem_rank;
              txr_d  = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          errp_d = 1'b1;
          errc_d = errc_q + CNT_W'(1);
        end
      end
      S_TX: begin
        if (bus.tx_ack) begin
          txr_d = 1'b0;
          if (bus.tx_done) begin
            deqc_d = deqc_q + CNT_W'(1);
            if (fifo_keep) begin
              rev_d  = 1'b1;
              reid_d = txid_q;
            end
          end
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done) begin
          deqc_d = deqc_q + CNT_W'(1);
          if (fifo_keep) begin
            rev_d  = 1'b1;
            reid_d = txid_q;
          end
        end
      end
      S_REENQ: begin
        if (bus.reenq_ready) rev_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign bus.pieo_deq_trigger = trig_q;
  assign bus.tx_req           = txr_q;
  assign bus.tx_fifo_id       = txid_q;
  assign bus.tx_rank          = txrk_q;
  assign bus.reenq_valid      = rev_q;
  assign bus.reenq_fifo_id    = reid_q;
  assign busy                 = state_q != S_IDLE;
  assign err_pulse            = errp_q;
  assign deq_count            = deqc_q;
  assign err_count            = errc_q;

endmodule

// File: tb/tb_pieo_post_deq_priority.sv
// Directed bench for pieo_post_deq_priority with tx/re-enqueue
// scoreboard queues; inputs change and outputs are read on negedge
module tb_pieo_post_deq_priority;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, err_pulse;
  logic [31:0] deq_count, err_count;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_tx[$];
  logic [1:0] exp_re[$];

  pieo_post_deq_priority_if #(
    .NUM_FIFO(3), .ID_LOG(2), .RANK_LOG(1), .TIME_LOG(1)
  ) bus ();

  pieo_post_deq_priority #(
    .NUM_FIFO(3), .ID_LOG(2), .RANK_LOG(1),
    .TIME_LOG(1), .TIMEOUT_LOG(3), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .err_pulse(err_pulse),
    .deq_count(deq_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    bus.pieo_ready_for_deq = 1'b0;
    bus.tx_enable          = 1'b0;
    bus.pieo_deq_valid     = 1'b0;
    bus.pieo_deq_empty     = 1'b0;
    bus.pieo_deq_element   = '0;
    bus.tx_ack             = 1'b0;
    bus.tx_done            = 1'b0;
    bus.reenq_ready        = 1'b0;
  endtask

  // trigger one dequeue and answer it two cycles after the trigger
  task automatic start_deq(input logic [3:0] elem, input logic emp);
    bus.pieo_ready_for_deq = 1'b1;
    bus.tx_enable = 1'b1;
    step();
    chk("trig_hi", 32'(bus.pieo_deq_trigger), 1);
    chk("busy_req", 32'(busy), 1);
    bus.pieo_ready_for_deq = 1'b0;
    bus.tx_enable = 1'b0;
    step();
    chk("trig_lo", 32'(bus.pieo_deq_trigger), 0);
    step();
    bus.pieo_deq_valid = 1'b1;
    bus.pieo_deq_empty = emp;
    bus.pieo_deq_element = elem;
    if (!emp && elem[1:0] != 2'd3)
      exp_tx.push_back(elem[2:0]);
    step();
    bus.pieo_deq_valid = 1'b0;
    bus.pieo_deq_empty = 1'b0;
  endtask

  task automatic expect_tx();
    logic [2:0] e;
    int n;
    n = 0;
    while (!bus.tx_req && n < 20) begin
      step();
      n++;
    end
    if (!bus.tx_req) begin
      chk("tx_req_wait", 0, 1);
    end else if (exp_tx.size() == 0) begin
      chk("tx_unexpected", 1, 0);
    end else begin
      e = exp_tx.pop_front();
      chk("tx_fifo_id", 32'(bus.tx_fifo_id), 32'(e[1:0]));
      chk("tx_rank", 32'(bus.tx_rank), 32'(e[2]));
    end
  endtask

  task automatic expect_re();
    logic [1:0] e;
    int n;
    n = 0;
    while (!bus.reenq_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.reenq_valid) begin
      chk("reenq_wait", 0, 1);
    end else if (exp_re.size() == 0) begin
      chk("reenq_unexpected", 1, 0);
    end else begin
      e = exp_re.pop_front();
      chk("reenq_id", 32'(bus.reenq_fifo_id), 32'(e));
    end
  endtask

  initial begin
    idle_inputs();
    bus.fifo_empty = 3'b000;

    // reset with inputs toggling
    for (int i = 0; i < 3; i++) begin
      bus.pieo_ready_for_deq = 1'($urandom);
      bus.tx_enable          = 1'($urandom);
      bus.pieo_deq_valid     = 1'($urandom);
      bus.pieo_deq_empty     = 1'($urandom);
      bus.pieo_deq_element   = 4'($urandom);
      bus.tx_ack             = 1'($urandom);
      bus.tx_done            = 1'($urandom);
      bus.reenq_ready        = 1'($urandom);
      bus.fifo_empty         = 3'($urandom);
      step();
    end
    chk("rst_trig", 32'(bus.pieo_deq_trigger), 0);
    chk("rst_txreq", 32'(bus.tx_req), 0);
    chk("rst_txid", 32'(bus.tx_fifo_id), 0);
    chk("rst_reenq", 32'(bus.reenq_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_pulse), 0);
    chk("rst_deqc", deq_count, 0);
    chk("rst_errc", err_count, 0);
    idle_inputs();
    rst_n = 1'b1;
    step();

    // tx_enable low keeps the block idle
    bus.pieo_ready_for_deq = 1'b1;
    step();
    step();
    chk("noen_trig", 32'(bus.pieo_deq_trigger), 0);
    chk("noen_busy", 32'(busy), 0);
    bus.pieo_ready_for_deq = 1'b0;

    // basic serve, FIFO 2 drains
    bus.fifo_empty = 3'b100;
    start_deq({1'b1, 1'b1, 2'd2}, 1'b0);
    expect_tx();
    step();
    chk("txreq_hold", 32'(bus.tx_req), 1);
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    chk("txreq_drop", 32'(bus.tx_req), 0);
    chk("busy_wd", 32'(busy), 1);
    step();
    step();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("basic_deqc", deq_count, 1);
    chk("basic_noreenq", 32'(bus.reenq_valid), 0);
    chk("basic_idle", 32'(busy), 0);

    // re-enqueue with 4 cycles of backpressure
    bus.fifo_empty = 3'b000;
    start_deq({1'b0, 1'b0, 2'd1}, 1'b0);
    expect_tx();
    bus.tx_ack = 1'b1;
    step();
    bus.tx_ack = 1'b0;
    bus.tx_done = 1'b1;
    exp_re.push_back(2'd1);
    step();
    bus.tx_done = 1'b0;
    expect_re();
    chk("re_deqc", deq_count, 2);
    for (int i = 0; i < 5; i++) begin
      chk("re_hold_v", 32'(bus.reenq_valid), 1);
      chk("re_hold_id", 32'(bus.reenq_fifo_id), 1);
      if (i == 4) bus.reenq_ready = 1'b1;
      step();
    end
    bus.reenq_ready = 1'b0;
    chk("re_drop", 32'(bus.reenq_valid), 0);
    chk("re_idle", 32'(busy), 0);

    // empty PIEO response
    start_deq(4'd0, 1'b1);
    chk("emp_idle", 32'(busy), 0);
    chk("emp_errc", err_count, 0);
    chk("emp_errp", 32'(err_pulse), 0);
    chk("emp_txreq", 32'(bus.tx_req), 0);

    // out-of-range FIFO ID
    start_deq({1'b0, 1'b1, 2'd3}, 1'b0);
    chk("bad_errp", 32'(err_pulse), 1);
    chk("bad_errc", err_count, 1);
    chk("bad_idle", 32'(busy), 0);
    chk("bad_txreq", 32'(bus.tx_req), 0);
    step();
    chk("bad_errp_1cyc", 32'(err_pulse), 0);

    // element wait timeout (7 cycles with TIMEOUT_LOG=3)
    bus.pieo_ready_for_deq = 1'b1;
    bus.tx_enable = 1'b1;
    step();
    chk("to_trig", 32'(bus.pieo_deq_trigger), 1);
    bus.pieo_ready_for_deq = 1'b0;
    bus.tx_enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_wait_busy", 32'(busy), 1);
      chk("to_wait_err", 32'(err_pulse), 0);
    end
    step();
    chk("to_errp", 32'(err_pulse), 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_errc", err_count, 2);
    step();
    chk("to_errp_1cyc", 32'(err_pulse), 0);

    // tx_done before tx_ack is ignored, then ack+done together
    start_deq({1'b1, 1'b0, 2'd0}, 1'b0);
    expect_tx();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("early_done_req", 32'(bus.tx_req), 1);
    chk("early_done_deqc", deq_count, 2);
    bus.tx_ack = 1'b1;
    bus.tx_done = 1'b1;
    exp_re.push_back(2'd0);
    step();
    bus.tx_ack = 1'b0;
    bus.tx_done = 1'b0;
    chk("short_deqc", deq_count, 3);
    chk("short_txreq", 32'(bus.tx_req), 0);
    expect_re();
    step();
    chk("short_hold", 32'(bus.reenq_valid), 1);

    // reset while in REENQ
    rst_n = 1'b0;
    step();
    chk("mid_rst_reenq", 32'(bus.reenq_valid), 0);
    chk("mid_rst_idle", 32'(busy), 0);
    chk("mid_rst_deqc", deq_count, 0);
    rst_n = 1'b1;
    step();

    // reenq_ready already high: one-cycle valid
    bus.reenq_ready = 1'b1;
    start_deq({1'b0, 1'b1, 2'd2}, 1'b0);
    expect_tx();
    bus.tx_ack = 1'b1;
    bus.tx_done = 1'b1;
    exp_re.push_back(2'd2);
    step();
    bus.tx_ack = 1'b0;
    bus.tx_done = 1'b0;
    expect_re();
    step();
    chk("fast_drop", 32'(bus.reenq_valid), 0);
    chk("fast_idle", 32'(busy), 0);
    chk("fast_deqc", deq_count, 1);
    chk("hold_txid", 32'(bus.tx_fifo_id), 2);
    chk("hold_txrk", 32'(bus.tx_rank), 1);
    bus.reenq_ready = 1'b0;

    chk("sb_tx_empty", 32'(exp_tx.size()), 0);
    chk("sb_re_empty", 32'(exp_re.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pieo_post_deq_priority.md
Name: pieo_post_deq_priority

Overview:
- Dequeue-side counterpart of the priority pre-enqueue stage.
- Pulls the head element from the PIEO and unpacks {send_time, rank, fifo_id}.
- Issues a transmit request for that FIFO and waits for completion.
- If the FIFO still holds packets, hands its ID back to the enq FIFO tracker for re-insertion.

Parameters:
- NUM_FIFO, 3, number of per-flow FIFOs.
- ID_LOG, 2, FIFO ID width.
- RANK_LOG, 1, rank (priority) width.
- TIME_LOG, 1, send_time width.
- TIMEOUT_LOG, 8, width of the element-wait timeout counter; timeout = 2^TIMEOUT_LOG-1 cycles.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- pieo_ready_for_deq  in  1  PIEO can accept a dequeue command.
- pieo_deq_trigger  out  1  one-cycle dequeue command to PIEO.
- pieo_deq_valid  in  1  PIEO dequeue response valid.
- pieo_deq_empty  in  1  qualifies pieo_deq_valid: no eligible element.
- pieo_deq_element  in  ID_LOG+RANK_LOG+TIME_LOG  {send_time, rank, fifo_id}, fifo_id in LSBs.
- fifo_empty  in  NUM_FIFO  per-FIFO empty flags from the FIFO tracker.
- tx_enable  in  1  downstream allows scheduling.
- tx_req  out  1  transmit request.
- tx_fifo_id  out  ID_LOG  FIFO to transmit from.
- tx_rank  out  RANK_LOG  rank of the element being served.
- tx_ack  in  1  downstream accepted tx_req.
- tx_done  in  1  packet fully sent.
- reenq_valid  out  1  request re-enqueue of reenq_fifo_id.
- reenq_fifo_id  out  ID_LOG  FIFO ID to re-enqueue.
- reenq_ready  in  1  tracker accepts re-enqueue.
- busy  out  1  state != IDLE.
- err_pulse  out  1  one-cycle error (timeout or bad ID).
- deq_count  out  CNT_W  elements served (tx completed).
- err_count  out  CNT_W  error events.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at clk edge, any state): state=IDLE; all outputs 0; counters 0; timeout counter 0. Reset mid-transaction abandons it and does not re-enqueue.
- States: IDLE, REQ, WAIT_ELEM, TX, WAIT_DONE, REENQ.

State transitions:
- **IDLE:** if pieo_ready_for_deq && tx_enable, go to REQ; pieo_deq_trigger=1 in the REQ cycle only (exactly one cycle; latency 1 from the sampled condition).
- **REQ:** go to WAIT_ELEM unconditionally; clear the timeout counter.
- **WAIT_ELEM:**
  - On pieo_deq_valid && pieo_deq_empty: go to IDLE with no error.
  - On pieo_deq_valid && !pieo_deq_empty: latch the element.
    - If fifo_id >= NUM_FIFO: err_pulse, err_count+1, go to IDLE.
    - Otherwise set tx_fifo_id=fifo_id, tx_rank=rank, tx_req=1, go to TX.
  - Otherwise increment the timeout counter. On reaching 2^TIMEOUT_LOG-1: err_pulse, err_count+1, go to IDLE.
  - A response arriving in the same cycle as the timeout wins.
- **TX:** tx_req is held high until tx_ack is sampled, then tx_req=0.
  - If tx_done is also high in that cycle, go directly to the REENQ decision; otherwise go to WAIT_DONE.
  - tx_done sampled before tx_ack is ignored.
- **WAIT_DONE:** on tx_done, deq_count+1, then evaluate fifo_empty[tx_fifo_id] in the same cycle.
  - If 0: reenq_valid=1, reenq_fifo_id=tx_fifo_id, go to REENQ.
  - If 1: go to IDLE.
  - The TX shortcut path also increments deq_count.
- **REENQ:** hold reenq_valid and reenq_fifo_id stable until reenq_ready; drop reenq_valid on the acceptance cycle and go to IDLE. If reenq_ready is already high on the first REENQ cycle, the transfer completes there (1-cycle valid).
- tx_enable is only checked in IDLE; deasserting it mid-transaction does not abort.
- Counters wrap modulo 2^CNT_W.
- err_pulse is high for exactly one cycle per event.
- tx_fifo_id and tx_rank hold their last value until the next element is latched.
- Element unpack: fifo_id=elem[ID_LOG-1:0], rank=elem[ID_LOG+:RANK_LOG], send_time=elem[ID_LOG+RANK_LOG+:TIME_LOG]. send_time is unused beyond unpacking; eligibility is decided by the PIEO.
- Minimum loop: IDLE→REQ→WAIT_ELEM→TX→IDLE. Throughput is at most one element per 4 cycles.

Test Plan:
- **Reset:** hold rst_n=0 for 3 cycles with all inputs toggling → all outputs 0, busy=0, counters 0.
- **Basic serve:**
  - Stimulus: ready=1, tx_enable=1; response element {1,1,2'd2} two cycles after the trigger; tx_ack 1 cycle later; tx_done 3 cycles later; fifo_empty=3'b100.
  - Required: single-cycle trigger; tx_req with tx_fifo_id=2, tx_rank=1; deq_count=1; no reenq_valid; back in IDLE.
- **Re-enqueue with backpressure:**
  - Stimulus: element fifo_id=1, fifo_empty=3'b000; reenq_ready held low 4 cycles.
  - Required: reenq_valid=1 with reenq_fifo_id=1 stable for 5 cycles, dropping after acceptance.
- **Empty PIEO and bad ID:**
  - Stimulus: response with pieo_deq_empty=1 → IDLE, err_count=0.
  - Stimulus: element fifo_id=3 (NUM_FIFO=3) → err_pulse once, err_count=1, no tx_req.
- **Timeout:**
  - Stimulus: no pieo_deq_valid after the trigger (TIMEOUT_LOG=3).
  - Required: err_pulse exactly 7 cycles into WAIT_ELEM; IDLE next cycle; err_count=1.
- **Ordering and reset mid-transaction:**
  - Stimulus: tx_done pulsed before tx_ack → ignored; then tx_ack and tx_done in the same cycle → deq_count+1, goes straight to the REENQ decision.
  - Stimulus: assert rst_n=0 while in REENQ → reenq_valid=0 on the next cycle, state IDLE.
